multi_latching_barrier: RTL



---
 rtl/multi_latching_barrier.sv | 109 ++++++++++
 1 files changed

// File: rtl/multi_latching_barrier.sv
// Multi-channel enabled latching barrier with stability filter and change strobe.
// Optional per-channel change counters are built when MULTI_LATCHING_BARRIER_CHANGE_COUNT_EN is defined.
module multi_latching_barrier #(
    parameter int unsigned WIDTH         = 1,
    parameter int unsigned CHANNELS      = 1,
    parameter int unsigned STAGES        = 2,
    parameter int unsigned STABLE_CYCLES = 1,
    parameter int unsigned CNT_WIDTH     = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS-1:0]          enable,
    input  logic [CHANNELS*WIDTH-1:0]    in,
    output logic [CHANNELS*WIDTH-1:0]    out,
    output logic [CHANNELS-1:0]          changed
`ifdef MULTI_LATCHING_BARRIER_CHANGE_COUNT_EN
    ,
    input  logic                         clear_counts,
    output logic [CHANNELS*CNT_WIDTH-1:0] change_count
`endif
);

    localparam int unsigned RUN_W  = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned PIPE_N = (STAGES >= 2) ? STAGES - 1 : 1;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);

    if (STAGES < 2) begin : g_bad_stages
        $error("multi_latching_barrier: STAGES must be 2 or more");
    end
    if (STABLE_CYCLES < 1) begin : g_bad_stable
        $error("multi_latching_barrier: STABLE_CYCLES must be 1 or more");
    end
    if (CNT_WIDTH < 1) begin : g_bad_cnt
        $error("multi_latching_barrier: CNT_WIDTH must be 1 or more");
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [WIDTH-1:0] pipe [PIPE_N];
        logic [WIDTH-1:0] in_c;
        logic [WIDTH-1:0] s_last;
        logic [WIDTH-1:0] cand_r;
        logic [WIDTH-1:0] out_r;
        logic [RUN_W-1:0] run_r;
        logic [RUN_W-1:0] run_next_c;
        logic             upd_c;
        logic             chg_r;

        assign in_c   = in[c*WIDTH +: WIDTH];
        assign s_last = pipe[PIPE_N-1];

        // Run length of identical s_last samples, saturating at the window size
        always_comb begin
            run_next_c = RUN_W'(1);
            upd_c      = 1'b0;
            if (s_last == cand_r) begin
                run_next_c = (run_r >= RUN_MAX) ? RUN_MAX : run_r + RUN_W'(1);
            end
            upd_c = (run_next_c == RUN_MAX) && (s_last != out_r);
        end

        // Pipeline, filter state and output; changed is the only ungated register
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int unsigned k = 0; k < PIPE_N; k++) begin
                    pipe[k] <= '0;
                end
                cand_r <= '0;
                run_r  <= '0;
                out_r  <= '0;
                chg_r  <= 1'b0;
            end else begin
                chg_r <= 1'b0;
                if (enable[c]) begin
                    pipe[0] <= in_c;
                    for (int unsigned k = 1; k < PIPE_N; k++) begin
                        pipe[k] <= pipe[k-1];
                    end
                    cand_r <= s_last;
                    run_r  <= run_next_c;
                    if (upd_c) begin
                        out_r <= s_last;
                        chg_r <= 1'b1;
                    end
                end
            end
        end

        assign out[c*WIDTH +: WIDTH] = out_r;
        assign changed[c]            = chg_r;

`ifdef MULTI_LATCHING_BARRIER_CHANGE_COUNT_EN
        logic [CNT_WIDTH-1:0] cnt_r;

        // Saturating count of change pulses; clear wins over a coincident pulse
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_r <= '0;
            end else if (clear_counts) begin
                cnt_r <= '0;
            end else if (chg_r && (cnt_r != {CNT_WIDTH{1'b1}})) begin
                cnt_r <= cnt_r + CNT_WIDTH'(1);
            end
        end

        assign change_count[c*CNT_WIDTH +: CNT_WIDTH] = cnt_r;
`endif
    end

endmodule
